// File: rtl/universal_shift_reg.sv
// Universal shift register with an automatic LSB-first parallel-in/serial-out
// transfer engine.
//
// state | meaning
// IDLE  | mode selects hold / shift right / shift left / load; start begins a transfer
// XFER  | shift right every edge, counting bits; last edge returns to IDLE and pulses done
//
// In XFER the serial input keeps shifting in from the top, so after a full
// transfer q holds the WIDTH sin samples with the earliest one in q[0].
module universal_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  // Serial output is always the current LSB; it follows reset combinationally.
  assign sout = q[0];

  // State, data, counter and flag registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      q     <= q_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state and next-data logic; done defaults low so it can only pulse.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_nxt     = q;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (start) begin
          // start wins over mode and is honoured even in the done cycle
          q_nxt     = d;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = XFER;
        end else begin
          case (mode)
            2'b00: q_nxt = q;
            2'b01: q_nxt = {sin, q[WIDTH-1:1]};
            2'b10: q_nxt = {q[WIDTH-2:0], sin};
            2'b11: q_nxt = d;
            default: q_nxt = q;
          endcase
        end
      end
      XFER: begin
        // mode and start are deliberately not looked at here
        q_nxt = {sin, q[WIDTH-1:1]};
        if (cnt == LAST) begin
          // wrap to zero rather than increment so unused codes stay unreachable
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt  = cnt + 1'b1;
          busy_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_universal_shift_reg.sv
// Testbench for universal_shift_reg (WIDTH=8): table-driven IDLE operations,
// scoreboard of expected post-edge state, and hand-written transfer/reset sequences.
module tb_universal_shift_reg;
  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d;
  logic [1:0] mode;
  logic       sin;
  logic       start;
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;

  universal_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .mode  (mode),
    .sin   (sin),
    .start (start),
    .q     (q),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] d;
    logic       sin;
    logic [7:0] q;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [7:0] dv, input logic s, input logic st);
    mode  = m;
    d     = dv;
    sin   = s;
    start = st;
  endtask

  task automatic push(input logic [7:0] eq, input logic eb, input logic ed);
    exp_t e;
    e.q    = eq;
    e.busy = eb;
    e.done = ed;
    sb.push_back(e);
  endtask

  // One clock edge, then compare the DUT against the oldest expectation.
  task automatic step(input string name);
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got q=%0h", name, q);
    end else begin
      e = sb.pop_front();
      check({name, " q"}, 32'(q), 32'(e.q));
      check({name, " busy"}, 32'(busy), 32'(e.busy));
      check({name, " done"}, 32'(done), 32'(e.done));
      check({name, " sout"}, 32'(sout), 32'(e.q[0]));
    end
  endtask

  task automatic check_reset_now(input string name);
    check({name, " q"}, 32'(q), 32'h00);
    check({name, " busy"}, 32'(busy), 32'h0);
    check({name, " done"}, 32'(done), 32'h0);
    check({name, " sout"}, 32'(sout), 32'h0);
  endtask

  // Full transfer of dv; sins[k] is driven in XFER cycle k. With disturb set,
  // start/mode/d are wiggled during XFER and must have no effect.
  task automatic xfer(input logic [7:0] dv, input logic [7:0] sins, input bit disturb,
                      input string tag);
    logic [7:0] m;
    drive(2'b00, dv, 1'b0, 1'b1);
    push(dv, 1'b1, 1'b0);
    step({tag, " start"});
    m = dv;
    for (int k = 0; k < 8; k++) begin
      if (disturb) drive(2'b11, 8'hFF, sins[k], 1'b1);
      else drive(2'b00, dv, sins[k], 1'b0);
      m = {sins[k], m[7:1]};
      if (k < 7) push(m, 1'b1, 1'b0);
      else push(sins, 1'b0, 1'b1);
      step($sformatf("%s k%0d", tag, k));
    end
  endtask

  initial begin
    vecs[0] = '{2'b11, 8'hA5, 1'b0, 8'hA5};
    vecs[1] = '{2'b00, 8'h00, 1'b1, 8'hA5};
    vecs[2] = '{2'b00, 8'hFF, 1'b0, 8'hA5};
    vecs[3] = '{2'b00, 8'h5A, 1'b1, 8'hA5};
    vecs[4] = '{2'b01, 8'h00, 1'b1, 8'hD2};
    vecs[5] = '{2'b10, 8'hFF, 1'b0, 8'hA4};
    vecs[6] = '{2'b10, 8'h00, 1'b1, 8'h49};
    vecs[7] = '{2'b01, 8'h00, 1'b0, 8'h24};
    vecs[8] = '{2'b11, 8'h3C, 1'b1, 8'h3C};
    vecs[9] = '{2'b00, 8'hFF, 1'b1, 8'h3C};

    rst_n = 1'b1;
    drive(2'b00, 8'h00, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_now("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].mode, vecs[i].d, vecs[i].sin, 1'b0);
      push(vecs[i].q, 1'b0, 1'b0);
      step($sformatf("vec%0d", i));
    end

    // asynchronous reset mid-cycle from a nonzero value
    #2 rst_n = 1'b0;
    #1 check_reset_now("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b00, 8'hFF, 1'b1, 1'b0);
    push(8'h00, 1'b0, 1'b0);
    step("post rst hold");
    drive(2'b11, 8'h5A, 1'b0, 1'b0);
    push(8'h5A, 1'b0, 1'b0);
    step("post rst load");

    xfer(8'h96, 8'h00, 1'b0, "x1");
    drive(2'b00, 8'h00, 1'b0, 1'b0);
    push(8'h00, 1'b0, 1'b0);
    step("x1 after");

    xfer(8'h5A, 8'hB1, 1'b1, "x2");
    xfer(8'hC3, 8'h6E, 1'b0, "x3");
    drive(2'b00, 8'h00, 1'b0, 1'b0);
    push(8'h6E, 1'b0, 1'b0);
    step("x3 after");

    // reset abandons a transfer in XFER cycle 3
    drive(2'b00, 8'h96, 1'b0, 1'b1);
    push(8'h96, 1'b1, 1'b0);
    step("ab start");
    for (int k = 0; k < 3; k++) begin
      drive(2'b00, 8'h96, 1'b0, 1'b0);
      push(8'h96 >> (k + 1), 1'b1, 1'b0);
      step($sformatf("ab k%0d", k));
    end
    #2 rst_n = 1'b0;
    #1 check_reset_now("ab rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push(8'h00, 1'b0, 1'b0);
      step($sformatf("ab idle%0d", k));
    end
    xfer(8'hE7, 8'h35, 1'b0, "x4");
    drive(2'b00, 8'h00, 1'b0, 1'b0);
    push(8'h35, 1'b0, 1'b0);
    step("x4 after");

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard leftover: %0d entries, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits; legal range is WIDTH >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 d  input  WIDTH  parallel data in.
REQ-005 mode  input  2  operation select in IDLE: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 sin  input  1  serial data in for all shift operations.
REQ-007 start  input  1  request an automatic parallel-in/serial-out transfer of d.
REQ-008 q  output  WIDTH  register contents, registered.
REQ-009 sout  output  1  serial data out; SHALL equal q[0] at all times (LSB-first).
REQ-010 busy  output  1  high while a transfer is in progress, registered.
REQ-011 done  output  1  one-cycle pulse marking transfer completion, registered.

Function
REQ-012 The block SHALL implement a two-state machine, IDLE and XFER, plus a bit counter of clog2(WIDTH) bits.
REQ-013 In IDLE with start=0, mode 00 SHALL hold q.
REQ-014 In IDLE with start=0, mode 01 SHALL load q with {sin, q[WIDTH-1:1]}.
REQ-015 In IDLE with start=0, mode 10 SHALL load q with {q[WIDTH-2:0], sin}.
REQ-016 In IDLE with start=0, mode 11 SHALL load q with d.
REQ-017 All IDLE operations SHALL take effect at the next rising edge (latency 1).
REQ-018 In IDLE with start=1, the block SHALL load q with d, clear the counter, set busy=1 and enter XFER; start SHALL take priority over mode.
REQ-019 In XFER, every edge SHALL shift right as in REQ-014 and increment the counter, so that bit d[k] appears on sout during XFER cycle k (k = 0..WIDTH-1).
REQ-020 On the edge where the counter equals WIDTH-1, the block SHALL perform the final shift, return to IDLE, set busy=0 and set done=1.
REQ-021 After a transfer, q SHALL hold the WIDTH bits taken from sin, with the earliest sampled bit in q[0].
REQ-022 done SHALL be high for exactly one cycle, the first IDLE cycle after the transfer, and SHALL be low in every other cycle.
REQ-023 In XFER, mode and start SHALL be ignored; a transfer cannot be aborted or restarted except by reset.
REQ-024 start asserted in the same cycle that done is high SHALL begin a new transfer; back-to-back transfers are therefore separated by exactly one IDLE cycle.
REQ-025 The counter SHALL never exceed WIDTH-1; for non-power-of-two WIDTH, unused counter codes SHALL be unreachable.

Reset
REQ-026 rst_n low SHALL immediately set q=0, busy=0, done=0, counter=0 and state IDLE, without waiting for a clock edge; sout therefore becomes 0.
REQ-027 Reset during XFER SHALL abandon the transfer with no done pulse.
REQ-028 After rst_n deasserts, the first active edge SHALL obey the IDLE rules.

Verification (WIDTH=8)
REQ-029 Assert rst_n=0 mid-cycle -> q=0x00, busy=0, done=0, sout=0 before the next edge.
REQ-030 mode=11, d=0xA5, then mode=00 for 3 cycles -> q=0xA5 after the load edge, unchanged through the hold cycles.
REQ-031 From q=0xA5, mode=01 with sin=1 -> q=0xD2; then mode=10 with sin=0 -> q=0xA4.
REQ-032 start=1 with d=0x96, sin=0 -> busy high for 8 cycles; sout sequence 0,1,1,0,1,0,0,1; then done=1 for one cycle with busy=0 and q=0x00.
REQ-033 During a transfer, drive start=1 and mode=11 with d=0xFF -> sout sequence unchanged, and no reload occurs.
REQ-034 rst_n=0 in XFER cycle 3 -> q=0x00 and busy=0 immediately; done stays 0; the next start runs a full 8-bit transfer.
